// File: rtl/approx_mult_seq.sv
// Wide multiplier sequencer that time-shares one external 4x4 approximate multiplier.
// Optional zero-pair skipping: define APPROX_MULT_SEQ_ZERO_SKIP_EN.
module approx_mult_seq #(
  parameter int NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic [3:0]             mul_a,
  output logic [3:0]             mul_b,
  input  logic [7:0]             mul_r,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NIBBLES-1:0]   result,
  output logic                   busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int RW    = 2 * W;
  localparam int STEPS = NIBBLES * NIBBLES;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_n;
  logic [SW-1:0]   step_r, step_n;
  logic [RW-1:0]   acc_r, acc_n;
  logic [W-1:0]    a_r, a_n;
  logic [W-1:0]    b_r, b_n;
  logic [RW-1:0]   result_r, result_n;
  logic            out_valid_r, out_valid_n;
  logic            in_ready_r;
  logic            busy_r;
  logic [RW-1:0]   pp_s;
`ifdef APPROX_MULT_SEQ_ZERO_SKIP_EN
  logic [SW:0]     live_s;
`endif

  function automatic logic [3:0] nib(input logic [W-1:0] v, input int idx);
    return v[4*idx +: 4];
  endfunction

  // Step s pairs A nibble (s mod NIBBLES) with B nibble (s div NIBBLES).
  function automatic logic [RW-1:0] shift_pp(input logic [7:0] p, input int s);
    return RW'(p) << (4 * ((s % NIBBLES) + (s / NIBBLES)));
  endfunction

`ifdef APPROX_MULT_SEQ_ZERO_SKIP_EN
  // Returns {found, step} for the lowest step >= from whose nibble pair is all nonzero.
  function automatic logic [SW:0] next_live(input logic [W-1:0] va, input logic [W-1:0] vb,
                                            input int from);
    logic          found;
    logic [SW-1:0] s;
    logic          hit;
    found = 1'b0;
    s     = {SW{1'b0}};
    for (int k = STEPS - 1; k >= 0; k--) begin
      hit   = (k >= from) && (nib(va, k % NIBBLES) != 4'd0) && (nib(vb, k / NIBBLES) != 4'd0);
      found = found | hit;
      s     = hit ? SW'(k) : s;
    end
    return {found, s};
  endfunction
`endif

  // Next-state, datapath and shared-multiplier operand decode.
  always_comb begin
    state_n     = state_r;
    step_n      = step_r;
    acc_n       = acc_r;
    a_n         = a_r;
    b_n         = b_r;
    result_n    = result_r;
    out_valid_n = out_valid_r;
    mul_a       = 4'd0;
    mul_b       = 4'd0;
    pp_s        = shift_pp(mul_r, int'(step_r));
`ifdef APPROX_MULT_SEQ_ZERO_SKIP_EN
    live_s      = {(SW+1){1'b0}};
`endif
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          a_n     = a;
          b_n     = b;
          acc_n   = {RW{1'b0}};
          step_n  = {SW{1'b0}};
          state_n = ST_MUL;
`ifdef APPROX_MULT_SEQ_ZERO_SKIP_EN
          live_s = next_live(a, b, 0);
          if (live_s[SW]) begin
            step_n = live_s[SW-1:0];
          end else begin
            result_n    = {RW{1'b0}};
            out_valid_n = 1'b1;
            state_n     = ST_DONE;
          end
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_MUL: begin
        mul_a  = nib(a_r, int'(step_r) % NIBBLES);
        mul_b  = nib(b_r, int'(step_r) / NIBBLES);
        acc_n  = acc_r + pp_s;
`ifdef APPROX_MULT_SEQ_ZERO_SKIP_EN
        live_s = next_live(a_r, b_r, int'(step_r) + 1);
        if (live_s[SW]) begin
          step_n  = live_s[SW-1:0];
          state_n = ST_MUL;
        end else begin
          result_n    = acc_r + pp_s;
          out_valid_n = 1'b1;
          state_n     = ST_DONE;
        end
`else
        step_n = step_r + SW'(1);
        if (step_r == SW'(STEPS - 1)) begin
          result_n    = acc_r + pp_s;
          out_valid_n = 1'b1;
          state_n     = ST_DONE;
        end else begin
          state_n = ST_MUL;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: begin
        state_n     = ST_IDLE;
        out_valid_n = 1'b0;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      step_r      <= {SW{1'b0}};
      acc_r       <= {RW{1'b0}};
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      result_r    <= {RW{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      step_r      <= step_n;
      acc_r       <= acc_n;
      a_r         <= a_n;
      b_r         <= b_n;
      result_r    <= result_n;
      out_valid_r <= out_valid_n;
      in_ready_r  <= (state_n == ST_IDLE);
      busy_r      <= (state_n != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_approx_mult_seq.sv
// Scoreboard bench for approx_mult_seq with an exact 4x4 multiplier model.
module tb_approx_mult_seq;

  localparam int NIB = 2;
  localparam int W   = 4 * NIB;
  localparam int RW  = 2 * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    mul_a;
  logic [3:0]    mul_b;
  logic [7:0]    mul_r;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic          busy;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp_val;
  logic [3:0]    exp_ma[4];
  logic [3:0]    exp_mb[4];

  approx_mult_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  assign mul_r = {4'd0, mul_a} * {4'd0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %0h want none at %0t", result, $time);
      end else begin
        exp_val = exp_q.pop_front();
        check("result", result, exp_val);
      end
    end
  end

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [RW-1:0] e,
                      input bit push, input bit hold, output int acc_cyc);
    int guard;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    exp_ma = '{4'hB, 4'hA, 4'hB, 4'hA};
    exp_mb = '{4'hD, 4'hD, 4'hC, 4'hC};
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 0xAB * 0xCD: nibble order and latency
    out_ready = 1'b1;
    send(8'hAB, 8'hCD, 16'h88EF, 1'b1, 1'b0, t1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        check("mul_a_seq", 64'(mul_a), 64'(exp_ma[k]));
        check("mul_b_seq", 64'(mul_b), 64'(exp_mb[k]));
        check("busy_mul", 64'(busy), 64'd1);
        check("ov_early", 64'(out_valid), 64'd0);
      end else begin
        check("ov_latency", 64'(out_valid), 64'd1);
      end
    end
    @(posedge clk);
    #1;
    check("ready_after_done", 64'(in_ready), 64'd1);
    check("ov_cleared", 64'(out_valid), 64'd0);

    // 0xFF * 0xFF with consumer stalled
    out_ready = 1'b0;
    send(8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, t1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_ov", 64'(out_valid), 64'd1);
      check("stall_result", 64'(result), 64'hFE01);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_mul_ab", 64'({mul_a, mul_b}), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("ready_after_stall", 64'(in_ready), 64'd1);

    // Back-to-back with in_valid held high
    send(8'h12, 8'h34, 16'h03A8, 1'b1, 1'b1, t1);
    send(8'h00, 8'h99, 16'h0000, 1'b1, 1'b0, t2);
    check("b2b_spacing", 64'(t2 - t1), 64'd6);
    drain();

    // Reset in MUL step 2 aborts the op
    send(8'hAB, 8'hCD, 16'h0000, 1'b0, 1'b0, t1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_mul_a", 64'(mul_a), 64'hB);
    check("pre_rst_mul_b", 64'(mul_b), 64'hC);
    #1;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_stale_ov", 64'(out_valid), 64'd0);
    end
    send(8'h02, 8'h03, 16'h0006, 1'b1, 1'b0, t1);
    drain();

`ifdef APPROX_MULT_SEQ_ZERO_SKIP_EN
    // Zero-pair skipping
    send(8'h0F, 8'h03, 16'h002D, 1'b1, 1'b0, t1);
    @(negedge clk);
    check("skip_one_step_ov0", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("skip_one_step_ov1", 64'(out_valid), 64'd1);
    drain();
    send(8'h00, 8'h55, 16'h0000, 1'b1, 1'b0, t1);
    @(negedge clk);
    check("skip_all_zero_ov", 64'(out_valid), 64'd1);
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
